// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: address/data/response widths, response codes and the
// single-beat command record used by local request ports.
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
    } axi_lite_cmd_t;

    function automatic logic resp_is_err(input resp_t resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle (AR, R, AW, W, B) with master and slave views.
interface axi_lite_if;
    import axi_lite_pkg::*;

    addr_t               araddr;
    logic                arvalid;
    logic                arready;
    data_t               rdata;
    resp_t               rresp;
    logic                rvalid;
    logic                rready;
    addr_t               awaddr;
    logic                awvalid;
    logic                awready;
    data_t               wdata;
    logic [STRB_W-1:0]   wstrb;
    logic                wvalid;
    logic                wready;
    resp_t               bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a local cmd/rsp port to the bus.
// Define AXI_LITE_MASTER_PARALLEL_AW_W_EN to issue AW and W concurrently.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    axi_lite_if.master        m_axi_lite
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
`ifdef AXI_LITE_MASTER_PARALLEL_AW_W_EN
        ST_WADDRDATA,
`else
        ST_WADDR,
        ST_WDATA,
`endif
        ST_WRESP,
        ST_RSP
    } state_t;

    localparam int CNT_RD  = 0;
    localparam int CNT_WR  = 1;
    localparam int CNT_ERR = 2;
    localparam int N_CNT   = 3;

    state_t        state_reg;
    state_t        state_next;
    axi_lite_cmd_t cmd_reg;
    logic          rsp_write_reg;
    data_t         rsp_rdata_reg;
    resp_t         rsp_resp_reg;

    logic ar_valid;
    logic r_ready;
    logic aw_valid;
    logic w_valid;
    logic b_ready;
    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic rd_done;
    logic wr_done;

    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_reg [N_CNT];

`ifdef AXI_LITE_MASTER_PARALLEL_AW_W_EN
    logic aw_done_reg;
    logic w_done_reg;
`endif

    // Every handshake output is a decode of registered state only.
    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
        rsp_valid = (state_reg == ST_RSP);
        ar_valid  = (state_reg == ST_RADDR);
        r_ready   = (state_reg == ST_RDATA);
        b_ready   = (state_reg == ST_WRESP);
`ifdef AXI_LITE_MASTER_PARALLEL_AW_W_EN
        aw_valid  = (state_reg == ST_WADDRDATA) && !aw_done_reg;
        w_valid   = (state_reg == ST_WADDRDATA) && !w_done_reg;
`else
        aw_valid  = (state_reg == ST_WADDR);
        w_valid   = (state_reg == ST_WDATA);
`endif
    end

    assign ar_hs   = ar_valid && m_axi_lite.arready;
    assign aw_hs   = aw_valid && m_axi_lite.awready;
    assign w_hs    = w_valid && m_axi_lite.wready;
    assign rd_done = r_ready && m_axi_lite.rvalid;
    assign wr_done = b_ready && m_axi_lite.bvalid;

    // Payload buses read as zero whenever their valid is low.
    assign m_axi_lite.arvalid = ar_valid;
    assign m_axi_lite.araddr  = ar_valid ? cmd_reg.addr : '0;
    assign m_axi_lite.rready  = r_ready;
    assign m_axi_lite.awvalid = aw_valid;
    assign m_axi_lite.awaddr  = aw_valid ? cmd_reg.addr : '0;
    assign m_axi_lite.wvalid  = w_valid;
    assign m_axi_lite.wdata   = w_valid ? cmd_reg.wdata : '0;
    assign m_axi_lite.wstrb   = w_valid ? '1 : '0;
    assign m_axi_lite.bready  = b_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
`ifdef AXI_LITE_MASTER_PARALLEL_AW_W_EN
                    state_next = cmd_write ? ST_WADDRDATA : ST_RADDR;
`else
                    state_next = cmd_write ? ST_WADDR : ST_RADDR;
`endif
                end
            end
            ST_RADDR: if (ar_hs) state_next = ST_RDATA;
            ST_RDATA: if (rd_done) state_next = ST_RSP;
`ifdef AXI_LITE_MASTER_PARALLEL_AW_W_EN
            ST_WADDRDATA: begin
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = ST_WRESP;
                end
            end
`else
            ST_WADDR: if (aw_hs) state_next = ST_WDATA;
            ST_WDATA: if (w_hs) state_next = ST_WRESP;
`endif
            ST_WRESP: if (wr_done) state_next = ST_RSP;
            ST_RSP:   if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= '0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= RESP_OKAY;
        end else begin
            state_reg <= state_next;
            if (cmd_ready && cmd_valid) begin
                cmd_reg <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
            end
            if (rd_done) begin
                rsp_write_reg <= cmd_reg.write;
                rsp_rdata_reg <= m_axi_lite.rdata;
                rsp_resp_reg  <= m_axi_lite.rresp;
            end
            if (wr_done) begin
                rsp_write_reg <= cmd_reg.write;
                rsp_rdata_reg <= '0;
                rsp_resp_reg  <= m_axi_lite.bresp;
            end
        end
    end

`ifdef AXI_LITE_MASTER_PARALLEL_AW_W_EN
    // Each channel drops its valid after its own handshake; flags clear outside the merged state.
    always_ff @(posedge aclk) begin
        if (areset || state_reg != ST_WADDRDATA) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_reg <= 1'b1;
            if (w_hs)  w_done_reg  <= 1'b1;
        end
    end
`endif

    assign cnt_inc[CNT_RD]  = rd_done;
    assign cnt_inc[CNT_WR]  = wr_done;
    assign cnt_inc[CNT_ERR] = (rd_done && resp_is_err(m_axi_lite.rresp))
                           || (wr_done && resp_is_err(m_axi_lite.bresp));

    // Statistics counters wrap freely.
    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            always_ff @(posedge aclk) begin
                if (areset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign rd_cnt    = cnt_reg[CNT_RD];
    assign wr_cnt    = cnt_reg[CNT_WR];
    assign err_cnt   = cnt_reg[CNT_ERR];
    assign rsp_write = rsp_write_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

endmodule
